// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Brief    : Pixel input and timing/colour outputs of the VGA timing generator.
// Revision : 1.0
// ============================================================================
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic [7:0]    pixel_in;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          bright;
    logic          pix_en;
    logic          line_start;
    logic          frame_start;
    logic [2:0]    r;
    logic [2:0]    g;
    logic [1:0]    b;
    logic          hsync;
    logic          vsync;

    modport master (
        input  pixel_in,
        output hcount, vcount, bright, pix_en, line_start, frame_start,
        output r, g, b, hsync, vsync
    );

    modport slave (
        output pixel_in,
        input  hcount, vcount, bright, pix_en, line_start, frame_start,
        input  r, g, b, hsync, vsync
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parameterised VGA raster timing with registered sync and RGB.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);
    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_dw      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_dw-1:0] c_div_last = c_dw'(CLK_DIV - 1);
    localparam logic [CW-1:0]   c_h_last   = CW'(c_h_total - 1);
    localparam logic [CW-1:0]   c_v_last   = CW'(c_v_total - 1);
    localparam logic [CW-1:0]   c_h_act    = CW'(H_ACTIVE);
    localparam logic [CW-1:0]   c_v_act    = CW'(V_ACTIVE);
    localparam logic [CW-1:0]   c_hs_first = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0]   c_hs_last  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0]   c_vs_first = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0]   c_vs_last  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [c_dw-1:0] r_div;
    logic [CW-1:0]   r_hcount;
    logic [CW-1:0]   r_vcount;
    logic [7:0]      r_rgb;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_line_start;
    logic            r_frame_start;

    logic w_div_last;
    logic w_pix_en;
    logic w_h_wrap;
    logic w_v_wrap;
    logic w_bright;
    logic w_hs_act;
    logic w_vs_act;

    assign w_div_last = (r_div == c_div_last);
    // Gated by rst so a CLK_DIV of 1 still shows no strobe while held in reset.
    assign w_pix_en   = w_div_last & ~rst;
    assign w_h_wrap   = (r_hcount == c_h_last);
    assign w_v_wrap   = (r_vcount == c_v_last);
    assign w_bright   = (r_hcount < c_h_act) && (r_vcount < c_v_act);
    assign w_hs_act   = (r_hcount >= c_hs_first) && (r_hcount <= c_hs_last);
    assign w_vs_act   = (r_vcount >= c_vs_first) && (r_vcount <= c_vs_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_dw'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_pix_en) begin
            r_hcount <= w_h_wrap ? '0 : r_hcount + CW'(1);
            if (w_h_wrap) begin
                r_vcount <= w_v_wrap ? '0 : r_vcount + CW'(1);
            end
        end
    end

    // Sync and colour sample the pre-increment position, so both lag the counters by one pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb   <= '0;
            r_hsync <= ~HS_POL;
            r_vsync <= ~VS_POL;
        end else if (w_pix_en) begin
            r_rgb   <= w_bright ? vga.pixel_in : 8'h00;
            r_hsync <= w_hs_act ? HS_POL : ~HS_POL;
            r_vsync <= w_vs_act ? VS_POL : ~VS_POL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_pix_en & w_h_wrap;
            r_frame_start <= w_pix_en & w_h_wrap & w_v_wrap;
        end
    end

    assign vga.hcount      = r_hcount;
    assign vga.vcount      = r_vcount;
    assign vga.bright      = w_bright;
    assign vga.pix_en      = w_pix_en;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;
    assign vga.r           = r_rgb[7:5];
    assign vga.g           = r_rgb[4:2];
    assign vga.b           = r_rgb[1:0];
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench: vector table, scoreboard run, reset and divider cases.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(CW)) vif ();
    vga_timing_gen_if #(.CW(CW)) vif1 ();

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vga (vif)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b0), .CW(CW)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .vga (vif1)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    endtask

    typedef struct {
        logic [7:0] pix;
        logic       pe;
        int         h;
        int         v;
        logic       ls;
        logic       br;
        logic [7:0] rgb;
        logic       hs;
    } vec_t;

    vec_t tbl [19];

    typedef struct packed {
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
    } out_t;

    out_t sb [$];
    out_t cur;

    logic [7:0] px;
    int         k, h, v, p;

    task automatic check_reset(input int idx);
        chk("rst_hcount", idx, vif.hcount, 0);
        chk("rst_vcount", idx, vif.vcount, 0);
        chk("rst_bright", idx, vif.bright, 1);
        chk("rst_pix_en", idx, vif.pix_en, 0);
        chk("rst_line_start", idx, vif.line_start, 0);
        chk("rst_frame_start", idx, vif.frame_start, 0);
        chk("rst_rgb", idx, {vif.r, vif.g, vif.b}, 0);
        chk("rst_hsync", idx, vif.hsync, 1);
        chk("rst_vsync", idx, vif.vsync, 1);
    endtask

    // Entered at edge+1 with rst just released; index i is clock cycle i+1 after release.
    task automatic run_table(input int pass);
        for (int i = 0; i < 19; i++) begin
            vif.pixel_in = tbl[i].pix;
            #1;
            chk("tbl_pix_en", pass * 100 + i, vif.pix_en, tbl[i].pe);
            chk("tbl_hcount", pass * 100 + i, vif.hcount, tbl[i].h);
            chk("tbl_vcount", pass * 100 + i, vif.vcount, tbl[i].v);
            chk("tbl_line_start", pass * 100 + i, vif.line_start, tbl[i].ls);
            chk("tbl_bright", pass * 100 + i, vif.bright, tbl[i].br);
            chk("tbl_rgb", pass * 100 + i, {vif.r, vif.g, vif.b}, tbl[i].rgb);
            chk("tbl_hsync", pass * 100 + i, vif.hsync, tbl[i].hs);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //               pix    pe    h  v  ls    br    rgb    hs
        tbl[0]  = '{8'h55, 1'b0, 0, 0, 1'b0, 1'b1, 8'h00, 1'b1};
        tbl[1]  = '{8'hA5, 1'b1, 0, 0, 1'b0, 1'b1, 8'h00, 1'b1};
        tbl[2]  = '{8'h55, 1'b0, 1, 0, 1'b0, 1'b1, 8'hA5, 1'b1};
        tbl[3]  = '{8'h3C, 1'b1, 1, 0, 1'b0, 1'b1, 8'hA5, 1'b1};
        tbl[4]  = '{8'h55, 1'b0, 2, 0, 1'b0, 1'b1, 8'h3C, 1'b1};
        tbl[5]  = '{8'hFF, 1'b1, 2, 0, 1'b0, 1'b1, 8'h3C, 1'b1};
        tbl[6]  = '{8'h55, 1'b0, 3, 0, 1'b0, 1'b1, 8'hFF, 1'b1};
        tbl[7]  = '{8'h81, 1'b1, 3, 0, 1'b0, 1'b1, 8'hFF, 1'b1};
        tbl[8]  = '{8'h55, 1'b0, 4, 0, 1'b0, 1'b0, 8'h81, 1'b1};
        tbl[9]  = '{8'h7E, 1'b1, 4, 0, 1'b0, 1'b0, 8'h81, 1'b1};
        tbl[10] = '{8'h55, 1'b0, 5, 0, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[11] = '{8'h7E, 1'b1, 5, 0, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[12] = '{8'h55, 1'b0, 6, 0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[13] = '{8'h7E, 1'b1, 6, 0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[14] = '{8'h55, 1'b0, 7, 0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[15] = '{8'h7E, 1'b1, 7, 0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[16] = '{8'h55, 1'b0, 0, 1, 1'b1, 1'b1, 8'h00, 1'b1};
        tbl[17] = '{8'hC3, 1'b1, 0, 1, 1'b0, 1'b1, 8'h00, 1'b1};
        tbl[18] = '{8'h55, 1'b0, 1, 1, 1'b0, 1'b1, 8'hC3, 1'b1};

        rst           = 1'b1;
        vif.pixel_in  = 8'h00;
        vif1.pixel_in = 8'h00;

        // Reset values, then the first line and a half from the vector table.
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        rst = 1'b0;
        run_table(0);

        // Two full frames with random pixels against the raster scoreboard.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset(1);
        rst = 1'b0;
        sb.delete();
        cur = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1};
        for (int c = 1; c <= 200; c++) begin
            px = 8'($urandom);
            vif.pixel_in = px;
            #1;
            k = (c - 1) / 2;
            h = k % 8;
            v = (k / 8) % 6;
            if (sb.size() > 0) cur = sb.pop_front();
            chk("sb_pix_en", c, vif.pix_en, (c % 2 == 0));
            chk("sb_hcount", c, vif.hcount, h);
            chk("sb_vcount", c, vif.vcount, v);
            chk("sb_bright", c, vif.bright, (h < 4 && v < 3));
            chk("sb_line_start", c, vif.line_start, (c > 1 && (c - 1) % 16 == 0));
            chk("sb_frame_start", c, vif.frame_start, (c > 1 && (c - 1) % 96 == 0));
            chk("sb_rgb", c, {vif.r, vif.g, vif.b}, cur.rgb);
            chk("sb_hsync", c, vif.hsync, cur.hs);
            chk("sb_vsync", c, vif.vsync, cur.vs);
            if (c % 2 == 0) begin
                sb.push_back('{rgb: (h < 4 && v < 3) ? px : 8'h00,
                               hs:  !(h >= 5 && h <= 6),
                               vs:  !(v == 4)});
            end
            @(posedge clk);
            #1;
        end

        // Mid-frame reset at (6,2) takes effect without a clock edge.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vif.pixel_in = 8'hFF;
        repeat (44) @(posedge clk);
        #1;
        chk("mid_hcount", 0, vif.hcount, 6);
        chk("mid_vcount", 0, vif.vcount, 2);
        #1;
        rst = 1'b1;
        #1;
        check_reset(2);
        @(posedge clk);
        #1;
        check_reset(3);
        rst = 1'b0;
        run_table(1);

        // CLK_DIV=1 with inverted hsync polarity.
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("div1_rst_pix_en", 0, vif1.pix_en, 0);
        chk("div1_rst_hsync", 0, vif1.hsync, 0);
        chk("div1_rst_vsync", 0, vif1.vsync, 1);
        chk("div1_rst_hcount", 0, vif1.hcount, 0);
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            p = c - 2;
            chk("div1_pix_en", c, vif1.pix_en, 1);
            chk("div1_hcount", c, vif1.hcount, (c - 1) % 8);
            chk("div1_hsync", c, vif1.hsync, (c > 1) && ((p % 8 == 5) || (p % 8 == 6)));
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- CLK_DIV, 4, clk cycles per pixel (>=1)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CW, 10, hcount/vcount width

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state on rising edge
- rst, in, 1, asynchronous active-high reset
- pixel_in, in, 8, {r[2:0],g[2:0],b[1:0]} for the current (hcount,vcount)
- hcount, out, CW, current pixel column
- vcount, out, CW, current line
- bright, out, 1, current position is in the active area
- pix_en, out, 1, one-clk pixel-advance strobe
- line_start, out, 1, one-clk pulse at hcount wrap to 0
- frame_start, out, 1, one-clk pulse at (hcount,vcount) wrap to (0,0)
- r, out, 3, registered red
- g, out, 3, registered green
- b, out, 2, registered blue
- hsync, out, 1, registered, aligned to rgb
- vsync, out, 1, registered, aligned to rgb

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; both SHALL fit in CW bits.
REQ-004 Divider counts 0..CLK_DIV-1 and wraps; pix_en SHALL be 1 exactly in the cycle the divider equals CLK_DIV-1. If CLK_DIV=1, pix_en SHALL be 1 every cycle.
REQ-005 On a pix_en cycle, hcount SHALL increment, wrapping from H_TOTAL-1 to 0. On no other cycle SHALL hcount change.
REQ-006 vcount SHALL increment only on a pix_en cycle where hcount=H_TOTAL-1, wrapping from V_TOTAL-1 to 0.
REQ-007 bright SHALL be the combinational decode (hcount<H_ACTIVE && vcount<V_ACTIVE) of the registered counters.
REQ-008 Sync decode SHALL be active when hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and likewise for vcount with the V parameters.
REQ-009 On pix_en, hsync/vsync SHALL register the decode at the polarity given by HS_POL/VS_POL. In the same cycle, {r,g,b} SHALL register pixel_in if bright, else 0. This gives one-pixel latency, with sync and rgb aligned.
REQ-010 line_start SHALL be 1 in the cycle after the pix_en that wraps hcount to 0. frame_start SHALL be 1 in the cycle after the pix_en that wraps both counters to 0.
REQ-011 Registered outputs SHALL hold their values between pix_en strobes.

Reset
REQ-012 While rst=1, the following SHALL hold:
- divider=0, hcount=0, vcount=0
- r=g=b=0
- hsync=~HS_POL, vsync=~VS_POL
- pix_en=0, line_start=0, frame_start=0
- bright=1, per the decode of (0,0)
REQ-013 Reset asserted mid-line or mid-frame SHALL return to REQ-012 values immediately, without waiting for a clock edge.
REQ-014 After deassertion, the first pix_en SHALL occur CLK_DIV cycles later.

Verification
(Bench parameters: H 4/1/2/1, so H_TOTAL=8; V 3/1/1/1, so V_TOTAL=6; CLK_DIV=2; HS_POL=VS_POL=0.)
REQ-015 Reset release -> pix_en on clk cycles 2, 4, 6, ...; hcount sequence 0,1,...,7,0; vcount increments to 1 on the 8th pix_en; line_start pulses once per 16 clks.
REQ-016 Hold pixel_in=8'hFF -> r=7, g=7, b=3 for 4 pixels per active line; rgb=0 for hcount 4-7 and for vcount 3-5.
REQ-017 Check sync timing -> hsync=0 for exactly 2 pixels, starting one pixel after hcount=5; vsync=0 for exactly one line (vcount=4, delayed one pixel); frame_start pulses once every 96 clks.
REQ-018 Assert rst while hcount=6, vcount=2 -> all outputs take REQ-012 values before the next clk edge; the sequence restarts from (0,0).
REQ-019 Set CLK_DIV=1 -> pix_en is constantly 1 and hcount advances every clk; set HS_POL=1 -> hsync is inverted relative to REQ-017.
